// File: rtl/alu_arbiter_if.sv
// Requester and ALU bus shared by alu_arbiter.
// Slave is the arbiter; master is the requester/ALU side.
interface alu_arbiter_if #(
    parameter int W = 32
) ();
    logic         req0_i;
    logic         req1_i;
    logic [2:0]   ctrl0_i;
    logic [2:0]   ctrl1_i;
    logic [W-1:0] data0a_i;
    logic [W-1:0] data0b_i;
    logic [W-1:0] data1a_i;
    logic [W-1:0] data1b_i;
    logic         gnt0_o;
    logic         gnt1_o;
    logic [W-1:0] alu_data1_o;
    logic [W-1:0] alu_data2_o;
    logic [2:0]   alu_ctrl_o;
    logic [W-1:0] alu_result_i;
    logic         valid_o;
    logic [W-1:0] result_o;
    logic         id_o;

    modport slave (
        input  req0_i, req1_i, ctrl0_i, ctrl1_i,
        input  data0a_i, data0b_i, data1a_i, data1b_i,
        input  alu_result_i,
        output gnt0_o, gnt1_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o,
        output valid_o, result_o, id_o
    );

    modport master (
        output req0_i, req1_i, ctrl0_i, ctrl1_i,
        output data0a_i, data0b_i, data1a_i, data1b_i,
        output alu_result_i,
        input  gnt0_o, gnt1_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o,
        input  valid_o, result_o, id_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters.
// MUL holds the ALU inputs MUL_LAT cycles, others one cycle.
module alu_arbiter #(
    parameter int MUL_LAT = 3,
    parameter int W       = 32
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_arbiter_if.slave bus
);
    localparam logic [2:0] MUL = 3'b010;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           owner;
    logic           gnt0;
    logic           gnt1;
    logic           take;
    logic           done;
    logic [2:0]     ctrl_sel;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_ctrl;
    logic           valid;
    logic [W-1:0]   result;
    logic           id;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (take) state_nxt = EXEC;
            EXEC: if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last holds the id of the most recent winner
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_i && state == IDLE) begin
            gnt0 = bus.req0_i && (!bus.req1_i || last);
            gnt1 = bus.req1_i && (!bus.req0_i || !last);
        end
    end

    assign take = gnt0 | gnt1;
    assign done = (state == EXEC) && (cnt == '0);

    always_comb begin
        ctrl_sel = bus.ctrl0_i;
        a_sel    = bus.data0a_i;
        b_sel    = bus.data0b_i;
        unique case (1'b1)
            gnt1: begin
                ctrl_sel = bus.ctrl1_i;
                a_sel    = bus.data1a_i;
                b_sel    = bus.data1b_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            last     <= 1'b1;
            owner    <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
        end else if (take) begin
            alu_a    <= a_sel;
            alu_b    <= b_sel;
            alu_ctrl <= ctrl_sel;
            owner    <= gnt1;
            last     <= gnt1;
            cnt      <= (ctrl_sel == MUL) ? CW'(MUL_LAT - 1) : '0;
        end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid  <= 1'b0;
            result <= '0;
            id     <= 1'b0;
        end else begin
            valid <= done;
            if (done) begin
                result <= bus.alu_result_i;
                id     <= owner;
            end
        end
    end

    assign bus.gnt0_o      = gnt0;
    assign bus.gnt1_o      = gnt1;
    assign bus.alu_data1_o = alu_a;
    assign bus.alu_data2_o = alu_b;
    assign bus.alu_ctrl_o  = alu_ctrl;
    assign bus.valid_o     = valid;
    assign bus.result_o    = result;
    assign bus.id_o        = id;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU.
// The ALU model only yields a MUL product once inputs have settled.
module tb_alu_arbiter;
    localparam int MUL_LAT = 3;
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] MUL = 3'b010;
    localparam logic [2:0] SRA = 3'b011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   held;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    logic [2:0]  prev_c;

    alu_arbiter_if #(.W(32)) bus ();

    alu_arbiter #(.MUL_LAT(MUL_LAT), .W(32)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count how long the ALU inputs have been stable
    always @(negedge clk) begin
        if (bus.alu_data1_o === prev_a && bus.alu_data2_o === prev_b &&
            bus.alu_ctrl_o === prev_c)
            held <= held + 1;
        else
            held <= 0;
        prev_a <= bus.alu_data1_o;
        prev_b <= bus.alu_data2_o;
        prev_c <= bus.alu_ctrl_o;
    end

    always_comb begin
        bus.alu_result_i = bus.alu_data1_o ^ bus.alu_data2_o;
        case (bus.alu_ctrl_o)
            ADD: bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
            SUB: bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
            MUL: bus.alu_result_i = (held >= MUL_LAT - 1) ?
                     bus.alu_data1_o * bus.alu_data2_o : 32'hDEADBEEF;
            SRA: bus.alu_result_i =
                     $signed(bus.alu_data1_o) >>> bus.alu_data2_o[4:0];
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        bus.req0_i   = r;
        bus.ctrl0_i  = c;
        bus.data0a_i = a;
        bus.data0b_i = b;
    endtask

    task automatic drive1(input logic r, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        bus.req1_i   = r;
        bus.ctrl1_i  = c;
        bus.data1a_i = a;
        bus.data1b_i = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive0(1'b1, ADD, 32'd5, 32'd7);
        drive1(1'b1, SUB, 32'd1, 32'd1);
        #1;
        checks++;
        if (bus.gnt0_o !== 1'b0 || bus.gnt1_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_gnt got %b%b exp 00", bus.gnt0_o, bus.gnt1_o);
        end
        checks++;
        if (bus.alu_data1_o !== 32'd0 || bus.alu_data2_o !== 32'd0 ||
            bus.alu_ctrl_o !== 3'd0) begin
            errors++;
            $display("FAIL rst_alu got %h %h %h exp 0", bus.alu_data1_o,
                     bus.alu_data2_o, bus.alu_ctrl_o);
        end
        checks++;
        if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd0 ||
            bus.id_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_out got %b %h %b exp 0", bus.valid_o,
                     bus.result_o, bus.id_o);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.gnt0_o !== 1'b1 || bus.gnt1_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_gnt got %b%b exp 10", bus.gnt0_o,
                     bus.gnt1_o);
        end
        step();
        drive0(1'b0, ADD, 0, 0);
        drive1(1'b0, ADD, 0, 0);
        step();
        step();
    endtask

    task automatic test_single_add();
        drive0(1'b1, ADD, 32'd5, 32'd7);
        #1;
        checks++;
        if (bus.gnt0_o !== 1'b1 || bus.gnt1_o !== 1'b0) begin
            errors++;
            $display("FAIL add_gnt got %b%b exp 10", bus.gnt0_o, bus.gnt1_o);
        end
        step();
        drive0(1'b0, ADD, 0, 0);
        #1;
        checks++;
        if (bus.alu_ctrl_o !== ADD || bus.alu_data1_o !== 32'd5 ||
            bus.alu_data2_o !== 32'd7 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL add_alu got %h %h %h %b exp 0 5 7 0",
                     bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o,
                     bus.valid_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd12 ||
            bus.id_o !== 1'b0) begin
            errors++;
            $display("FAIL add_res got %b %h %b exp 1 c 0", bus.valid_o,
                     bus.result_o, bus.id_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd12) begin
            errors++;
            $display("FAIL add_pulse got %b %h exp 0 c", bus.valid_o,
                     bus.result_o);
        end
    endtask

    task automatic test_mul();
        int gseen;
        int vseen;
        gseen = 0;
        vseen = 0;
        drive1(1'b1, MUL, -32'sd3, 32'd4);
        drive0(1'b1, ADD, 32'd1, 32'd2);
        #1;
        checks++;
        if (bus.gnt1_o !== 1'b1 || bus.gnt0_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_gnt got %b%b exp 01", bus.gnt0_o, bus.gnt1_o);
        end
        step();
        drive1(1'b0, ADD, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            if (bus.gnt0_o !== 1'b0) gseen++;
            if (bus.valid_o !== 1'b0) vseen++;
            step();
        end
        checks++;
        if (gseen != 0 || vseen != 0) begin
            errors++;
            $display("FAIL mul_hold got gnt0 %0d valid %0d exp 0 0",
                     gseen, vseen);
        end
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.result_o !== 32'hFFFFFFF4 ||
            bus.id_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_res got %b %h %b exp 1 fffffff4 1",
                     bus.valid_o, bus.result_o, bus.id_o);
        end
        checks++;
        if (bus.gnt0_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_next_gnt0 got %b exp 1", bus.gnt0_o);
        end
        step();
        drive0(1'b0, ADD, 0, 0);
        step();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd3 ||
            bus.id_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_follow got %b %h %b exp 1 3 0", bus.valid_o,
                     bus.result_o, bus.id_o);
        end
        step();
    endtask

    task automatic test_contention();
        logic        exp_id;
        logic [31:0] exp_res;
        drive0(1'b1, SUB, 32'd10, 32'd3);
        drive1(1'b1, SRA, 32'h80000000, 32'd4);
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 0);
            #1;
            checks++;
            if (bus.gnt1_o !== exp_id || bus.gnt0_o !== !exp_id) begin
                errors++;
                $display("FAIL cont_gnt%0d got %b%b exp %b%b", k,
                         bus.gnt0_o, bus.gnt1_o, !exp_id, exp_id);
            end
            if (k > 0) begin
                exp_res = exp_id ? 32'd7 : 32'hF8000000;
                checks++;
                if (bus.valid_o !== 1'b1 || bus.result_o !== exp_res ||
                    bus.id_o !== !exp_id) begin
                    errors++;
                    $display("FAIL cont_res%0d got %b %h %b exp 1 %h %b", k,
                             bus.valid_o, bus.result_o, bus.id_o, exp_res,
                             !exp_id);
                end
            end
            step();
            checks++;
            if (bus.gnt0_o !== 1'b0 || bus.gnt1_o !== 1'b0) begin
                errors++;
                $display("FAIL cont_exec%0d got %b%b exp 00", k,
                         bus.gnt0_o, bus.gnt1_o);
            end
            step();
        end
        drive0(1'b0, ADD, 0, 0);
        drive1(1'b0, ADD, 0, 0);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd7 ||
            bus.id_o !== 1'b0) begin
            errors++;
            $display("FAIL cont_last got %b %h %b exp 1 7 0", bus.valid_o,
                     bus.result_o, bus.id_o);
        end
        step();
    endtask

    task automatic test_withdrawn();
        int gseen;
        int vseen;
        gseen = 0;
        vseen = 0;
        drive1(1'b1, MUL, 32'd6, 32'd7);
        #1;
        checks++;
        if (bus.gnt1_o !== 1'b1) begin
            errors++;
            $display("FAIL wd_gnt1 got %b exp 1", bus.gnt1_o);
        end
        step();
        drive1(1'b0, ADD, 0, 0);
        drive0(1'b1, ADD, 32'd100, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) drive0(1'b0, ADD, 0, 0);
            #1;
            if (bus.gnt0_o !== 1'b0) gseen++;
            if (bus.valid_o === 1'b1) begin
                vseen++;
                checks++;
                if (bus.result_o !== 32'd42 || bus.id_o !== 1'b1 || i != 4) begin
                    errors++;
                    $display("FAIL wd_res cyc %0d got %h %b exp cyc 4 2a 1",
                             i, bus.result_o, bus.id_o);
                end
            end
            step();
        end
        checks++;
        if (gseen != 0 || vseen != 1) begin
            errors++;
            $display("FAIL wd_count got gnt0 %0d valid %0d exp 0 1",
                     gseen, vseen);
        end
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, ADD, 32'd1, 32'd1);
        #1;
        checks++;
        if (bus.gnt0_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gnt got %b exp 1", bus.gnt0_o);
        end
        step();
        drive0(1'b0, ADD, 0, 0);
        step();
        drive0(1'b1, ADD, 32'd2, 32'd3);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.gnt0_o !== 1'b1 ||
            bus.result_o !== 32'd2) begin
            errors++;
            $display("FAIL b2b_overlap got %b %b %h exp 1 1 2", bus.valid_o,
                     bus.gnt0_o, bus.result_o);
        end
        step();
        drive0(1'b0, ADD, 0, 0);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got %b exp 0", bus.valid_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd5 ||
            bus.id_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got %b %h %b exp 1 5 0", bus.valid_o,
                     bus.result_o, bus.id_o);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        drive0(1'b1, MUL, 32'd9, 32'd9);
        #1;
        checks++;
        if (bus.gnt0_o !== 1'b1) begin
            errors++;
            $display("FAIL rm_gnt got %b exp 1", bus.gnt0_o);
        end
        step();
        drive0(1'b0, ADD, 0, 0);
        step();
        rst_n = 1'b0;
        drive1(1'b1, ADD, 32'd20, 32'd22);
        #1;
        checks++;
        if (bus.alu_ctrl_o !== 3'd0 || bus.alu_data1_o !== 32'd0 ||
            bus.alu_data2_o !== 32'd0 || bus.valid_o !== 1'b0 ||
            bus.result_o !== 32'd0 || bus.id_o !== 1'b0 ||
            bus.gnt1_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_clear got %h %h %h %b %h %b %b exp all 0",
                     bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o,
                     bus.valid_o, bus.result_o, bus.id_o, bus.gnt1_o);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.gnt1_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_regrant got gnt1 %b valid %b exp 1 0",
                     bus.gnt1_o, bus.valid_o);
        end
        step();
        drive1(1'b0, ADD, 0, 0);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_stale got %b exp 0", bus.valid_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd42 ||
            bus.id_o !== 1'b1) begin
            errors++;
            $display("FAIL rm_res got %b %h %b exp 1 2a 1", bus.valid_o,
                     bus.result_o, bus.id_o);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive0(1'b0, ADD, 0, 0);
        drive1(1'b0, ADD, 0, 0);
        step();
        test_reset();
        test_single_add();
        test_mul();
        test_contention();
        test_withdrawn();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
